// File: rtl/ibuff_aligner.sv
`default_nettype none
// ibuff_aligner: fetch-stage-2 byte aligner. Holds the buffer instruction pointer,
// rotates the 64-byte line ring into a 16-byte decode window and advances by instruction length.
module ibuff_aligner #(
  parameter int LEN_W       = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [127:0]           line_00,
  input  logic                   line_00_valid,
  input  logic [127:0]           line_01,
  input  logic                   line_01_valid,
  input  logic [127:0]           line_10,
  input  logic                   line_10_valid,
  input  logic [127:0]           line_11,
  input  logic                   line_11_valid,
  input  logic                   resteer,
  input  logic [5:0]             resteer_BIP,
  input  logic                   dec_ready,
  input  logic [LEN_W-1:0]       dec_inst_len,
  output logic [127:0]           window,
  output logic                   window_valid,
  output logic [5:0]             old_BIP_fetch2,
  output logic [5:0]             new_BIP_fetch2,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [5:0]             bip_q, bip_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic [3:0]    line_vld;
  logic [1:0]    cur_line;
  logic [1:0]    nxt_line;
  logic          lines_ok;
  logic          win_vld;
  logic          consume;
  logic [1023:0] ring2;

  // The ring is laid out twice so a window starting near byte 63 reads straight into line 0.
  assign ring2    = {2{line_11, line_10, line_01, line_00}};
  assign window   = ring2[{bip_q, 3'b000} +: 128];

  assign line_vld = {line_11_valid, line_10_valid, line_01_valid, line_00_valid};
  assign cur_line = bip_q[5:4];
  assign nxt_line = cur_line + 2'd1;
  assign lines_ok = line_vld[cur_line] && ((bip_q[3:0] == 4'd0) || line_vld[nxt_line]);
  assign win_vld  = (state_q != S_IDLE) && lines_ok;
  assign consume  = win_vld && dec_ready && !resteer && (dec_inst_len != '0);

  assign window_valid   = win_vld;
  assign old_BIP_fetch2 = bip_q;
  assign new_BIP_fetch2 = bip_d;
  assign stall_cycles   = stall_q;

  always_comb begin
    bip_d   = bip_q;
    state_d = state_q;
    stall_d = stall_q;

    if (resteer) begin
      bip_d = resteer_BIP;
    end else if (consume) begin
      bip_d = bip_q + 6'(dec_inst_len);
    end

    case (state_q)
      S_IDLE: begin
        if (resteer) state_d = S_FILL;
      end
      S_FILL: begin
        if (resteer)       state_d = S_FILL;
        else if (lines_ok) state_d = S_RUN;
      end
      S_RUN: begin
        if (resteer || !lines_ok) state_d = S_FILL;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && !win_vld && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      bip_q   <= 6'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      bip_q   <= bip_d;
      stall_q <= stall_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ibuff_aligner.sv
`default_nettype none
// Scoreboard bench for ibuff_aligner: directed cycles push expected outputs, a monitor compares at negedge.
module tb_ibuff_aligner;

  logic         clk;
  logic         reset;
  logic [127:0] line_00, line_01, line_10, line_11;
  logic         line_00_valid, line_01_valid, line_10_valid, line_11_valid;
  logic         resteer;
  logic [5:0]   resteer_BIP;
  logic         dec_ready;
  logic [3:0]   dec_inst_len;
  logic [127:0] window;
  logic         window_valid;
  logic [5:0]   old_BIP_fetch2;
  logic [5:0]   new_BIP_fetch2;
  logic [15:0]  stall_cycles;

  typedef struct {
    string       name;
    logic        wv;
    logic [5:0]  ob;
    logic [5:0]  nb;
    logic [15:0] st;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  ibuff_aligner #(.LEN_W(4), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .line_00(line_00), .line_00_valid(line_00_valid),
    .line_01(line_01), .line_01_valid(line_01_valid),
    .line_10(line_10), .line_10_valid(line_10_valid),
    .line_11(line_11), .line_11_valid(line_11_valid),
    .resteer(resteer), .resteer_BIP(resteer_BIP),
    .dec_ready(dec_ready), .dec_inst_len(dec_inst_len),
    .window(window), .window_valid(window_valid),
    .old_BIP_fetch2(old_BIP_fetch2), .new_BIP_fetch2(new_BIP_fetch2),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ring byte b holds value b, so window byte i must equal (BIP+i) mod 64.
  function automatic logic [127:0] model_win(input logic [5:0] b);
    logic [127:0] w;
    logic [5:0]   idx;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      idx = b + 6'(i);
      w[8*i +: 8] = {2'b00, idx};
    end
    return w;
  endfunction

  task automatic push(input string nm, input logic wv, input logic [5:0] ob,
                      input logic [5:0] nb, input logic [15:0] st);
    exp_t e;
    e.name = nm; e.wv = wv; e.ob = ob; e.nb = nb; e.st = st;
    q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] vld, input logic rs, input logic [5:0] rb,
                        input logic rdy, input logic [3:0] len);
    {line_11_valid, line_10_valid, line_01_valid, line_00_valid} = vld;
    resteer = rs; resteer_BIP = rb; dec_ready = rdy; dec_inst_len = len;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (window_valid !== e.wv) begin
          errors++;
          $display("FAIL %s window_valid got %0b exp %0b", e.name, window_valid, e.wv);
        end
        checks++;
        if (old_BIP_fetch2 !== e.ob) begin
          errors++;
          $display("FAIL %s old_BIP got %h exp %h", e.name, old_BIP_fetch2, e.ob);
        end
        checks++;
        if (new_BIP_fetch2 !== e.nb) begin
          errors++;
          $display("FAIL %s new_BIP got %h exp %h", e.name, new_BIP_fetch2, e.nb);
        end
        checks++;
        if (stall_cycles !== e.st) begin
          errors++;
          $display("FAIL %s stall_cycles got %h exp %h", e.name, stall_cycles, e.st);
        end
        if (e.wv) begin
          checks++;
          if (window !== model_win(e.ob)) begin
            errors++;
            $display("FAIL %s window got %h exp %h", e.name, window, model_win(e.ob));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int k = 0; k < 16; k++) begin
      line_00[8*k +: 8] = 8'(k);
      line_01[8*k +: 8] = 8'(16 + k);
      line_10[8*k +: 8] = 8'(32 + k);
      line_11[8*k +: 8] = 8'(48 + k);
    end
    reset = 1'b0;
    set_in(4'b0000, 1'b0, 6'd0, 1'b0, 4'd0);
    #1;
    push("reset_state", 1'b0, 6'h00, 6'h00, 16'd0);
    next_cycle();
    next_cycle();
    reset = 1'b1;

    set_in(4'b1111, 1'b0, 6'd0, 1'b1, 4'd3);
    push("idle_no_window", 1'b0, 6'h00, 6'h00, 16'd0);
    next_cycle();
    set_in(4'b1111, 1'b1, 6'h05, 1'b1, 4'd3);
    push("idle_resteer", 1'b0, 6'h00, 6'h05, 16'd0);
    next_cycle();
    set_in(4'b1111, 1'b0, 6'h00, 1'b1, 4'd3);
    push("fill_consume3", 1'b1, 6'h05, 6'h08, 16'd0);
    next_cycle();
    set_in(4'b1111, 1'b0, 6'h00, 1'b0, 4'd3);
    push("run_not_ready", 1'b1, 6'h08, 6'h08, 16'd0);
    next_cycle();

    set_in(4'b1001, 1'b1, 6'h3C, 1'b0, 4'd0);
    push("run_line_gap_resteer", 1'b0, 6'h08, 6'h3C, 16'd0);
    next_cycle();
    set_in(4'b1001, 1'b0, 6'h00, 1'b1, 4'd7);
    push("wrap_window_len7", 1'b1, 6'h3C, 6'h03, 16'd1);
    next_cycle();
    set_in(4'b1001, 1'b0, 6'h00, 1'b0, 4'd0);
    push("run_after_wrap_gap", 1'b0, 6'h03, 6'h03, 16'd1);
    next_cycle();

    set_in(4'b0010, 1'b1, 6'h1A, 1'b0, 4'd0);
    push("fill_resteer_1A", 1'b0, 6'h03, 6'h1A, 16'd2);
    next_cycle();
    set_in(4'b0010, 1'b0, 6'h00, 1'b1, 4'd2);
    push("stall_a", 1'b0, 6'h1A, 6'h1A, 16'd3);
    next_cycle();
    push("stall_b", 1'b0, 6'h1A, 6'h1A, 16'd4);
    next_cycle();
    set_in(4'b0110, 1'b0, 6'h00, 1'b0, 4'd0);
    push("line2_arrives", 1'b1, 6'h1A, 6'h1A, 16'd5);
    next_cycle();

    set_in(4'b0110, 1'b1, 6'h20, 1'b1, 4'd4);
    push("resteer_beats_consume", 1'b1, 6'h1A, 6'h20, 16'd5);
    next_cycle();
    set_in(4'b0110, 1'b0, 6'h00, 1'b1, 4'd0);
    push("len0_fill", 1'b1, 6'h20, 6'h20, 16'd5);
    next_cycle();
    push("len0_run", 1'b1, 6'h20, 6'h20, 16'd5);
    next_cycle();
    set_in(4'b0110, 1'b0, 6'h00, 1'b1, 4'd15);
    push("consume15", 1'b1, 6'h20, 6'h2F, 16'd5);
    next_cycle();
    set_in(4'b0000, 1'b0, 6'h00, 1'b1, 4'd1);
    push("valids_dropped", 1'b0, 6'h2F, 6'h2F, 16'd5);
    next_cycle();

    repeat (65540) @(posedge clk);
    #1;
    push("stall_saturated", 1'b0, 6'h2F, 6'h2F, 16'hFFFF);
    next_cycle();
    push("stall_holds", 1'b0, 6'h2F, 6'h2F, 16'hFFFF);
    next_cycle();

    set_in(4'b1111, 1'b1, 6'h10, 1'b0, 4'd0);
    push("resteer_10", 1'b1, 6'h2F, 6'h10, 16'hFFFF);
    next_cycle();
    set_in(4'b1111, 1'b0, 6'h00, 1'b0, 4'd0);
    push("fill_10", 1'b1, 6'h10, 6'h10, 16'hFFFF);
    next_cycle();
    push("run_10", 1'b1, 6'h10, 6'h10, 16'hFFFF);
    next_cycle();
    set_in(4'b1111, 1'b0, 6'h00, 1'b1, 4'd3);
    #2;
    reset = 1'b0;
    push("async_reset_midcycle", 1'b0, 6'h00, 6'h00, 16'd0);
    next_cycle();
    reset = 1'b1;
    push("post_reset_idle", 1'b0, 6'h00, 6'h00, 16'd0);
    next_cycle();
    set_in(4'b1111, 1'b1, 6'h07, 1'b1, 4'd3);
    push("post_reset_resteer", 1'b0, 6'h00, 6'h07, 16'd0);
    next_cycle();
    set_in(4'b1111, 1'b0, 6'h00, 1'b0, 4'd0);
    push("post_reset_fill", 1'b1, 6'h07, 6'h07, 16'd0);
    next_cycle();

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
